key_event_arbiter: RTL
======================

// Module: key_event_arbiter
// PURPOSE
//  Debounces NUM_KEYS raw active-low push-buttons with one shared tick timer. Classifies each key into
//  PRESS / LONG / RELEASE events and round-robin arbitrates them onto a single valid/ready event stream.
//  Sits between board buttons and the UI/control FSM. Replaces per-key 20 ms debounce counters.
// PARAMETERS
//  NUM_KEYS     4          number of keys (2..16)
//  TICK_CYCLES  1_000_000  clocks per sample tick (20 ms at 50 MHz clk)
//  LONG_TICKS   50         ticks held after press acceptance before LONG event (1 s)
// PORTS
//  clk        in   1            system clock
//  rst_n      in   1            asynchronous active-low reset
//  key_in     in   NUM_KEYS     raw keys, asynchronous, 0 = pressed
//  key_state  out  NUM_KEYS     debounced level, 1 = pressed
//  evt_valid  out  1            event available
//  evt_ready  in   1            consumer accepts event
//  evt_key    out  clog2(NUM_KEYS)  key index of event
//  evt_type   out  2            01 PRESS, 10 LONG, 11 RELEASE (00 never driven with valid)
//  evt_ovf    out  1            1-cycle pulse: event merged into an already-pending identical event
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  - Reset: all outputs 0. Sync FFs = 1 (released). Stable levels = released. Per-key FSM = IDLE.
//    Reset also clears pending flags, prescaler and round-robin pointer (0).
//  - Reset mid-operation: pending events are discarded. No RELEASE is emitted.
//    A key still held after reset is re-debounced and produces a fresh PRESS.
//  - Sync: 2-FF synchroniser per key.
//  - Tick: prescaler runs 0..TICK_CYCLES-1 and wraps. tick=1 for one cycle when cnt==TICK_CYCLES-1.
//  - Debounce, per key, on tick only: sample = synced level. Register prev_sample.
//    New stable level is accepted when sample==prev_sample and sample!=stable.
//    Level must therefore agree on two consecutive ticks. key_state updates the cycle after the tick.
//  - Per-key FSM, advances on tick only:
//    IDLE    -> PRESSED on accepted press: raise PRESS, hold_cnt=0.
//    PRESSED -> hold_cnt+1 each tick. On the tick hold_cnt reaches LONG_TICKS-1: raise LONG, -> HELD.
//    PRESSED/HELD -> IDLE on accepted release: raise RELEASE.
//    hold_cnt saturates, no wrap. hold_cnt width clog2(LONG_TICKS+1).
//  - Pending flags: 3 per key (P, L, R), set the cycle after the raising tick.
//    Raise while flag already set: flag stays set, evt_ovf pulses once. Multiple keys same cycle: still one pulse.
//    Raise in the same cycle the flag is cleared by handshake: set wins, no ovf.
//  - Arbiter: output registers hold key/type.
//    When evt_valid=0 and any flag is pending, the next cycle loads the first key with a pending flag.
//    Search order is ptr, ptr+1, ... mod NUM_KEYS. Within a key: P before L before R.
//  - Handshake: evt_valid && evt_ready in the same cycle clears that flag, deasserts evt_valid next cycle,
//    and sets ptr = granted key + 1 mod NUM_KEYS.
//    Min one idle cycle between events: max throughput 1 event / 2 clocks.
//  - While evt_valid=1 and evt_ready=0: evt_key/evt_type are held stable. No re-arbitration.
//  - Latency: raising tick -> flag set (+1) -> evt_valid (+1 if output idle).
//  - evt_ready is ignored while evt_valid=0.
// TESTING  (TICK_CYCLES=10, LONG_TICKS=5, NUM_KEYS=4)
//  1. key0 toggles every 2 clk for 12 clk, then stays low 60 clk -> exactly one event {0,01}; key_state[0]=1.
//  2. key1 low for 8 clk (less than a tick interval) -> no event, key_state[1] stays 0, evt_ovf stays 0.
//  3. key2 held low 120 clk then released, ready=1 -> {2,01}; {2,10} 50 clk after PRESS flag; then {2,11}.
//  4. All 4 keys pressed same clk, ready=1 -> PRESS for keys 0,1,2,3 in that order, each valid 1 clk, 1-clk gaps.
//  5. ready=0; key0 press, release, press again -> valid held at {0,01}. evt_ovf pulses once (2nd PRESS).
//     Then ready=1 -> {0,01} followed by {0,11}.
//  6. rst_n low 3 clk while key3 held mid-PRESSED -> outputs 0 asynchronously, no RELEASE emitted.
//     After reset, a new {3,01} appears within 2 ticks + 4 clk.

Source files
------------

// File: rtl/key_event_arbiter.sv
// Shared-tick debouncer for NUM_KEYS active-low buttons. Each key is classified into
// PRESS / LONG / RELEASE events, which are arbitrated round-robin onto one valid/ready stream.
module key_event_arbiter #(
   parameter int NUM_KEYS    = 4,
   parameter int TICK_CYCLES = 1_000_000,
   parameter int LONG_TICKS  = 50
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_KEYS-1:0]         key_in,
   output logic [NUM_KEYS-1:0]         key_state,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [$clog2(NUM_KEYS)-1:0] evt_key,
   output logic [1:0]                  evt_type,
   output logic                        evt_ovf,
   output logic [2*NUM_KEYS-1:0]       dbg_key_fsm
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

   localparam int FLAG_P = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_R = 2;

   localparam logic [1:0] EVT_PRESS   = 2'b01;
   localparam logic [1:0] EVT_LONG    = 2'b10;
   localparam logic [1:0] EVT_RELEASE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } key_st_e;

   // ------------------------------------------------------------------
   // Shared sample tick
   // ------------------------------------------------------------------
   logic [TW-1:0] tick_cnt;
   logic          tick;

   assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Synchroniser and tick-sampled debounce (levels held as 1 = pressed)
   // ------------------------------------------------------------------
   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] sample;
   logic [NUM_KEYS-1:0] prev_sample;
   logic [NUM_KEYS-1:0] stable;
   logic [NUM_KEYS-1:0] acc_press;
   logic [NUM_KEYS-1:0] acc_rel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign sample = ~sync2;

   // A new level is accepted only after agreeing on two consecutive ticks.
   assign acc_press = {NUM_KEYS{tick}} &  sample &  prev_sample & ~stable;
   assign acc_rel   = {NUM_KEYS{tick}} & ~sample & ~prev_sample &  stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sample <= '0;
         stable      <= '0;
      end else if (tick) begin
         prev_sample <= sample;
         stable      <= (stable | acc_press) & ~acc_rel;
      end
   end

   assign key_state = stable;

   // ------------------------------------------------------------------
   // Per-key event FSM
   // ------------------------------------------------------------------
   key_st_e             state_q [NUM_KEYS];
   key_st_e             state_d [NUM_KEYS];
   logic [HW-1:0]       hold_q  [NUM_KEYS];
   logic [HW-1:0]       hold_d  [NUM_KEYS];
   logic [NUM_KEYS-1:0][2:0] raise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= ST_IDLE;
            hold_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= state_d[k];
            hold_q[k]  <= hold_d[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         state_d[k] = state_q[k];
         hold_d[k]  = hold_q[k];
         case (state_q[k])
            ST_IDLE: begin
               if (acc_press[k]) begin
                  state_d[k] = ST_PRESSED;
                  hold_d[k]  = '0;
               end
            end
            ST_PRESSED, ST_HELD: begin
               if (acc_rel[k]) begin
                  state_d[k] = ST_IDLE;
               end else if (tick) begin
                  if (state_q[k] == ST_PRESSED && hold_q[k] == HOLD_LONG) begin
                     state_d[k] = ST_HELD;
                  end
                  if (hold_q[k] != HOLD_MAX) begin
                     hold_d[k] = hold_q[k] + HW'(1);
                  end
               end
            end
            default: state_d[k] = ST_IDLE;
         endcase
      end
   end

   // LONG fires on the LONG_TICKS-th tick after acceptance; a release on that tick wins.
   always_comb begin
      raise       = '0;
      dbg_key_fsm = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         dbg_key_fsm[2*k +: 2] = state_q[k];
         raise[k][FLAG_P] = (state_q[k] == ST_IDLE) && acc_press[k];
         raise[k][FLAG_L] = (state_q[k] == ST_PRESSED) && tick && !acc_rel[k]
                            && (hold_q[k] == HOLD_LONG);
         raise[k][FLAG_R] = (state_q[k] != ST_IDLE) && acc_rel[k];
      end
   end

   // ------------------------------------------------------------------
   // Pending flags and round-robin output stage.
   // Handshake: an event transfers on any cycle with evt_valid && evt_ready;
   // while evt_valid is high and evt_ready low, evt_key/evt_type do not change;
   // evt_ready has no effect while evt_valid is low; after a transfer evt_valid
   // drops for at least one cycle before the next event is presented.
   // ------------------------------------------------------------------
   logic [NUM_KEYS-1:0][2:0] pend_q;
   logic [NUM_KEYS-1:0][2:0] clr;
   logic [KW-1:0]            ptr_q;
   logic                     grant_found;
   logic [KW-1:0]            grant_key;
   logic [1:0]               grant_type;
   logic [KW-1:0]            cand;
   int                       scan;

   always_comb begin
      clr = '0;
      if (evt_valid && evt_ready) begin
         clr[evt_key][evt_type - 2'd1] = 1'b1;
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_key   = '0;
      grant_type  = EVT_PRESS;
      scan        = 0;
      cand        = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         scan = int'(ptr_q) + i;
         if (scan >= NUM_KEYS) begin
            scan = scan - NUM_KEYS;
         end
         cand = KW'(scan);
         if (!grant_found && (|pend_q[cand])) begin
            grant_found = 1'b1;
            grant_key   = cand;
            if (pend_q[cand][FLAG_P]) begin
               grant_type = EVT_PRESS;
            end else if (pend_q[cand][FLAG_L]) begin
               grant_type = EVT_LONG;
            end else begin
               grant_type = EVT_RELEASE;
            end
         end
      end
   end

   // A raise coinciding with its own handshake clear re-arms the flag without overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= '0;
         evt_ovf   <= 1'b0;
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_type  <= '0;
         ptr_q     <= '0;
      end else begin
         pend_q  <= (pend_q & ~clr) | raise;
         evt_ovf <= |(raise & pend_q & ~clr);
         if (evt_valid) begin
            if (evt_ready) begin
               evt_valid <= 1'b0;
               ptr_q     <= (evt_key == KW'(NUM_KEYS - 1)) ? '0 : evt_key + KW'(1);
            end
         end else if (grant_found) begin
            evt_valid <= 1'b1;
            evt_key   <= grant_key;
            evt_type  <= grant_type;
         end
      end
   end

endmodule
